uart_rx_deserializer: RTL

//   Oversampling UART receiver that feeds the UART-side write port of the receive FIFO.

---
 rtl/uart_rx_deserializer.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/uart_rx_deserializer.sv
// Oversampling 8N1 UART receiver: synchronizes rx_serial, validates the start bit,
// samples data LSB-first at mid-bit and strobes each good byte into the receive FIFO.
//
// state       | meaning
// ------------+---------------------------------------------------------------
// S_IDLE      | line idle, waiting for rx_sync to go low
// S_START     | timing half a bit to re-check the start bit at its centre
// S_DATA      | sampling DATA_BITS data bits, one per bit period
// S_STOP      | sampling the stop bit; high -> write_req, low -> frame_error
// S_WAIT_IDLE | framing error seen, waiting for the line to return high
module uart_rx_deserializer #(
   parameter int CLKS_PER_BIT = 16,
   parameter int DATA_BITS    = 8,
   parameter int SYNC_STAGES  = 2
) (
   input  logic                 UART_CLK,
   input  logic                 reset_n,
   input  logic                 rx_serial,
   output logic                 write_req,
   output logic [DATA_BITS-1:0] write_data,
   output logic                 frame_error,
   output logic                 busy
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int BW = $clog2(DATA_BITS + 1);
   localparam logic [CW-1:0] HALF_TC = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL_TC = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_WAIT_IDLE
   } state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [BW-1:0]          bit_q, bit_d;
   logic [DATA_BITS-1:0]   shift_q, shift_d;
   logic [DATA_BITS-1:0]   data_q, data_d;
   logic                   wr_q, wr_d;
   logic                   fe_q, fe_d;
   logic                   rx_sync;

   assign rx_sync = sync_q[SYNC_STAGES-1];

   // Bit timing uses a down-counter loaded with the terminal value; the sample
   // point is where it reaches zero.
   always_comb begin
      state_d = state_q;
      sync_d  = {sync_q[SYNC_STAGES-2:0], rx_serial};
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      data_d  = data_q;
      wr_d    = 1'b0;
      fe_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!rx_sync) begin
               state_d = S_START;
               cnt_d   = HALF_TC;
            end
         end
         S_START: begin
            if (cnt_q == '0) begin
               if (!rx_sync) begin
                  state_d = S_DATA;
                  cnt_d   = FULL_TC;
                  bit_d   = '0;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_DATA: begin
            if (cnt_q == '0) begin
               shift_d = {rx_sync, shift_q[DATA_BITS-1:1]};
               cnt_d   = FULL_TC;
               if (bit_q == LAST_BIT) begin
                  state_d = S_STOP;
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_STOP: begin
            if (cnt_q == '0) begin
               if (rx_sync) begin
                  wr_d    = 1'b1;
                  data_d  = shift_q;
                  state_d = S_IDLE;
               end else begin
                  fe_d    = 1'b1;
                  state_d = S_WAIT_IDLE;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_WAIT_IDLE: begin
            if (rx_sync) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge UART_CLK) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         sync_q  <= '1;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         wr_q    <= 1'b0;
         fe_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         sync_q  <= sync_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         wr_q    <= wr_d;
         fe_q    <= fe_d;
      end
   end

   assign write_req   = wr_q;
   assign frame_error = fe_q;
   assign write_data  = data_q;
   assign busy        = (state_q != S_IDLE);

endmodule
